ctx_switch_ctrl: RTL and testbench

CTX_SWITCH_CTRL -- requirements
Module: ctx_switch_ctrl

---
 rtl/ctx_switch_ctrl.sv | 104 ++++++++++
 tb/tb_ctx_switch_ctrl.sv | 121 ++++++++++++
 2 files changed

// File: rtl/ctx_switch_ctrl.sv
// ctx_switch_ctrl: two-level interrupt context-switch sequencer driving register-file bank save/restore pulses
//   clk, rst_n                    : clock, asynchronous active-low reset
//   irq1, irq2                    : level interrupt requests (irq2 higher priority)
//   eret                          : return-from-interrupt strobe
//   snap_req, snap_restore        : software snapshot save/restore strobes
//   enable_*/restore_*            : one-cycle bank save/restore pulses
//   ack1, ack2                    : one-cycle interrupt-accepted pulses
//   level                         : 0 user, 1 ISR1, 2 ISR2
//   busy                          : high while any save/restore pulse is high
//   err                           : sticky, set by eret at level 0
//   Macro CTX_SNAPSHOT_EN enables the snapshot bank (BackUp2); otherwise snap inputs are ignored.
module ctx_switch_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       irq1,
  input  logic       irq2,
  input  logic       eret,
  input  logic       snap_req,
  input  logic       snap_restore,
  output logic       enable_userBackUp,
  output logic       enable_BackUp1,
  output logic       enable_BackUp2,
  output logic       restore_userBackUp,
  output logic       restore_BackUp1,
  output logic       restore_BackUp2,
  output logic       ack1,
  output logic       ack2,
  output logic [1:0] level,
  output logic       busy,
  output logic       err
);
  typedef enum logic [1:0] {USER, ISR1, ISR2U, ISR2I} state_t;
  state_t state;
`ifndef CTX_SNAPSHOT_EN
  logic unused_snap;
  assign unused_snap = snap_req | snap_restore;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= USER;
      level <= 2'd0;
      enable_userBackUp <= 1'b0;
      enable_BackUp1 <= 1'b0;
      enable_BackUp2 <= 1'b0;
      restore_userBackUp <= 1'b0;
      restore_BackUp1 <= 1'b0;
      restore_BackUp2 <= 1'b0;
      ack1 <= 1'b0;
      ack2 <= 1'b0;
      busy <= 1'b0;
      err <= 1'b0;
    end else begin
      enable_userBackUp <= 1'b0;
      enable_BackUp1 <= 1'b0;
      enable_BackUp2 <= 1'b0;
      restore_userBackUp <= 1'b0;
      restore_BackUp1 <= 1'b0;
      restore_BackUp2 <= 1'b0;
      ack1 <= 1'b0;
      ack2 <= 1'b0;
      busy <= 1'b0;
      // A cycle with a pulse high is a dead cycle: inputs are dropped, level requests re-seen next cycle.
      if (!busy) begin
        if (eret) begin
          if (state == USER) begin
            err <= 1'b1;
          end else if (state == ISR2I) begin
            restore_BackUp1 <= 1'b1;
            busy <= 1'b1;
            state <= ISR1;
            level <= 2'd1;
          end else begin
            restore_userBackUp <= 1'b1;
            busy <= 1'b1;
            state <= USER;
            level <= 2'd0;
          end
        end else if (irq2 && (state == USER || state == ISR1)) begin
          enable_userBackUp <= (state == USER);
          enable_BackUp1 <= (state == ISR1);
          ack2 <= 1'b1;
          busy <= 1'b1;
          state <= (state == USER) ? ISR2U : ISR2I;
          level <= 2'd2;
        end else if (irq1 && state == USER) begin
          enable_userBackUp <= 1'b1;
          ack1 <= 1'b1;
          busy <= 1'b1;
          state <= ISR1;
          level <= 2'd1;
        end
`ifdef CTX_SNAPSHOT_EN
        else if (snap_restore) begin
          restore_BackUp2 <= 1'b1;
          busy <= 1'b1;
        end else if (snap_req) begin
          enable_BackUp2 <= 1'b1;
          busy <= 1'b1;
        end
`endif
      end
    end
  end
endmodule

// File: tb/tb_ctx_switch_ctrl.sv
// tb_ctx_switch_ctrl: scoreboard bench for ctx_switch_ctrl using directed vectors
module tb_ctx_switch_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic irq1 = 1'b0, irq2 = 1'b0, eret = 1'b0, snap_req = 1'b0, snap_restore = 1'b0;
  logic enable_userBackUp, enable_BackUp1, enable_BackUp2;
  logic restore_userBackUp, restore_BackUp1, restore_BackUp2;
  logic ack1, ack2, busy, err;
  logic [1:0] level;
  logic [11:0] dut_vec;
  logic [11:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  localparam logic [11:0] EU = 12'h800, E1 = 12'h400, E2 = 12'h200, RU = 12'h100;
  localparam logic [11:0] R1 = 12'h080, R2 = 12'h040, A1 = 12'h020, A2 = 12'h010;
  localparam logic [11:0] L2 = 12'h008, L1 = 12'h004, B = 12'h002, ER = 12'h001;
`ifdef CTX_SNAPSHOT_EN
  localparam logic [11:0] SE = E2 | B, SR = R2 | B;
`else
  localparam logic [11:0] SE = 12'h000, SR = 12'h000;
`endif
  ctx_switch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .irq1(irq1), .irq2(irq2), .eret(eret),
    .snap_req(snap_req), .snap_restore(snap_restore),
    .enable_userBackUp(enable_userBackUp), .enable_BackUp1(enable_BackUp1), .enable_BackUp2(enable_BackUp2),
    .restore_userBackUp(restore_userBackUp), .restore_BackUp1(restore_BackUp1), .restore_BackUp2(restore_BackUp2),
    .ack1(ack1), .ack2(ack2), .level(level), .busy(busy), .err(err)
  );
  assign dut_vec = {enable_userBackUp, enable_BackUp1, enable_BackUp2, restore_userBackUp,
                    restore_BackUp1, restore_BackUp2, ack1, ack2, level, busy, err};
  always #5 clk = ~clk;
  // Each expectation describes the outputs after the edge that samples its inputs.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [11:0] e;
      e = exp_q.pop_front();
      checks++;
      if (dut_vec !== e) begin
        errors++;
        $display("FAIL step%0d outputs got %h expected %h", checks, dut_vec, e);
      end
    end
  end
  task automatic step(input logic i1, input logic i2, input logic er, input logic sq, input logic sr, input logic [11:0] e);
    @(negedge clk);
    #1;
    irq1 = i1; irq2 = i2; eret = er; snap_req = sq; snap_restore = sr;
    exp_q.push_back(e);
  endtask
  task automatic direct(input string name, input logic [11:0] got, input logic [11:0] e);
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, e);
    end
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #2;
    direct("reset_state", dut_vec, 12'h000);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0, 0, 0, 12'h000);
    step(1, 0, 0, 0, 0, EU | A1 | L1 | B);
    step(1, 0, 0, 0, 0, L1);
    step(1, 0, 0, 0, 0, L1);
    step(0, 1, 0, 0, 0, E1 | A2 | L2 | B);
    step(0, 1, 0, 0, 0, L2);
    step(1, 1, 0, 0, 0, L2);
    step(0, 0, 1, 0, 0, R1 | L1 | B);
    step(0, 0, 0, 0, 0, L1);
    step(0, 0, 1, 0, 0, RU | B);
    step(0, 0, 0, 0, 0, 12'h000);
    step(1, 1, 0, 0, 0, EU | A2 | L2 | B);
    step(0, 0, 0, 0, 0, L2);
    step(0, 0, 1, 0, 0, RU | B);
    step(0, 0, 0, 0, 0, 12'h000);
    step(1, 0, 0, 0, 0, EU | A1 | L1 | B);
    step(0, 0, 0, 0, 0, L1);
    step(0, 1, 1, 0, 0, RU | B);
    step(0, 1, 0, 0, 0, 12'h000);
    step(0, 1, 0, 0, 0, EU | A2 | L2 | B);
    step(0, 0, 0, 0, 0, L2);
    step(0, 0, 1, 0, 0, RU | B);
    step(0, 0, 0, 0, 0, 12'h000);
    step(0, 0, 1, 0, 0, ER);
    step(0, 0, 0, 0, 0, ER);
    step(1, 0, 0, 0, 0, EU | A1 | L1 | B | ER);
    step(0, 0, 0, 0, 0, L1 | ER);
    step(0, 0, 0, 1, 0, SE | L1 | ER);
    step(0, 0, 0, 0, 0, L1 | ER);
    step(0, 0, 0, 0, 1, SR | L1 | ER);
    step(0, 0, 0, 0, 0, L1 | ER);
    step(0, 0, 1, 0, 0, RU | B | ER);
    step(0, 0, 0, 0, 0, ER);
    @(negedge clk);
    @(negedge clk);
    #1;
    irq1 = 1'b1;
    @(posedge clk);
    #2;
    irq1 = 1'b0;
    direct("pulse_before_reset", dut_vec, EU | A1 | L1 | B | ER);
    rst_n = 1'b0;
    #1;
    direct("async_reset_clear", dut_vec, 12'h000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0, 0, 0, 12'h000);
    step(1, 0, 0, 0, 0, EU | A1 | L1 | B);
    step(0, 0, 0, 0, 0, L1);
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain pending %0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
